// File: rtl/uart_digit_receiver.sv
// rtl/uart_digit_receiver.sv - 8N1 UART receiver that rebuilds a 4-digit operand from digit bytes
module uart_digit_receiver #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] DIGIT_BASE   = 8'h30,
  parameter logic [7:0] TERM_BYTE    = 8'h0D,
  parameter logic [7:0] CLEAR_BYTE   = 8'h1B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [2:0] digitCount,
  output logic       frameValid,
  output logic       frameError,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          rx_meta, rxs;
  logic          accept, ferr;
  logic [3:0]    p1, p2, p3, p4;
  logic [7:0]    diff;
  logic          is_digit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
    end
  end

  // Counter is reloaded at every sample point so timing never drifts within a character.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    accept       = 1'b0;
    ferr         = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_next   = HALF_BIT;
          state_next = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (!rxs) begin
          cnt_next     = FULL_M1;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          shreg_next   = {rxs, shreg[7:1]};
          cnt_next     = FULL_M1;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (rxs) begin
          accept     = 1'b1;
          state_next = IDLE;
        end else begin
          ferr       = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign diff     = shreg - DIGIT_BASE;
  assign is_digit = (diff < 8'd10);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      p4         <= '0;
      num1       <= '0;
      num2       <= '0;
      num3       <= '0;
      num4       <= '0;
      digitCount <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameError <= ferr;
      if (accept) begin
        if (is_digit) begin
          p1 <= diff[3:0];
          p2 <= p1;
          p3 <= p2;
          p4 <= p3;
          if (digitCount != 3'd4) digitCount <= digitCount + 3'd1;
        end else if (shreg == TERM_BYTE) begin
          num1       <= p1;
          num2       <= p2;
          num3       <= p3;
          num4       <= p4;
          frameValid <= 1'b1;
          p1         <= '0;
          p2         <= '0;
          p3         <= '0;
          p4         <= '0;
          digitCount <= '0;
        end else if (shreg == CLEAR_BYTE) begin
          p1         <= '0;
          p2         <= '0;
          p3         <= '0;
          p4         <= '0;
          digitCount <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_digit_receiver.sv
// tb/tb_uart_digit_receiver.sv - directed bench for uart_digit_receiver
module tb_uart_digit_receiver;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [3:0] num1, num2, num3, num4;
  logic [2:0] digitCount;
  logic       frameValid, frameError, busy;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int busy_cyc = 0;

  uart_digit_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .num1(num1),
    .num2(num2),
    .num3(num3),
    .num4(num4),
    .digitCount(digitCount),
    .frameValid(frameValid),
    .frameError(frameError),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frameValid) fv_cnt++;
    if (frameError) fe_cnt++;
    if (busy) busy_cyc++;
    if (frameValid || frameError) check("pulse_exclusive", {31'd0, frameValid & frameError}, 32'd0);
  end

  task automatic hold(input logic v, input int cycles);
    rxd = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low = 0);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (stop_low > 0) hold(1'b0, stop_low * CPB);
    else hold(1'b1, CPB);
  endtask

  task automatic check_nums(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                            input logic [3:0] e3, input logic [3:0] e4);
    check({tag, "_num1"}, num1, e1);
    check({tag, "_num2"}, num2, e2);
    check({tag, "_num3"}, num3, e3);
    check({tag, "_num4"}, num4, e4);
  endtask

  initial begin
    reset = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check_nums("reset", 4'd0, 4'd0, 4'd0, 4'd0);
    check("reset_count", digitCount, 0);
    check("reset_busy", busy, 0);
    check("reset_fv", frameValid, 0);
    check("reset_fe", frameError, 0);
    reset = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    check("idle_fv", fv_cnt, 0);
    check("idle_fe", fe_cnt, 0);
    check("idle_busy", busy, 0);

    // "123" then terminator
    send_byte(8'h31);
    check("d1_count", digitCount, 1);
    send_byte(8'h32);
    check("d2_count", digitCount, 2);
    send_byte(8'h33);
    check("d3_count", digitCount, 3);
    check("pre_term_fv", fv_cnt, 0);
    send_byte(8'h0D);
    check("term1_fv", fv_cnt, 1);
    check_nums("c123", 4'd3, 4'd2, 4'd1, 4'd0);
    check("term1_count", digitCount, 0);

    // five digits saturate and drop the oldest
    send_byte(8'h39);
    send_byte(8'h38);
    send_byte(8'h37);
    send_byte(8'h36);
    check("sat4_count", digitCount, 4);
    send_byte(8'h35);
    check("sat5_count", digitCount, 4);
    check_nums("held", 4'd3, 4'd2, 4'd1, 4'd0);
    send_byte(8'h0D);
    check("term2_fv", fv_cnt, 2);
    check_nums("c98765", 4'd5, 4'd6, 4'd7, 4'd8);

    // clear byte and ignored byte
    send_byte(8'h34);
    check("clr_pre_count", digitCount, 1);
    send_byte(8'h1B);
    check("clr_count", digitCount, 0);
    check("clr_fv", fv_cnt, 2);
    check_nums("clr_keep", 4'd5, 4'd6, 4'd7, 4'd8);
    send_byte(8'h37);
    send_byte(8'h0D);
    check("term3_fv", fv_cnt, 3);
    check_nums("c7", 4'd7, 4'd0, 4'd0, 4'd0);
    send_byte(8'h41);
    check("ign_fv", fv_cnt, 3);
    check("ign_fe", fe_cnt, 0);
    check("ign_count", digitCount, 0);
    check_nums("ign", 4'd7, 4'd0, 4'd0, 4'd0);

    // framing error with stop bit held low (break)
    send_byte(8'h35, 3);
    check("ferr_fe", fe_cnt, 1);
    check("ferr_fv", fv_cnt, 3);
    check("ferr_count", digitCount, 0);
    check("ferr_wait_busy", busy, 1);
    hold(1'b1, 4);
    check("ferr_release_busy", busy, 0);
    check("ferr_fe_once", fe_cnt, 1);
    send_byte(8'h32);
    send_byte(8'h0D);
    check("term4_fv", fv_cnt, 4);
    check_nums("c2", 4'd2, 4'd0, 4'd0, 4'd0);

    // short start glitch
    hold(1'b1, 4);
    busy_cyc = 0;
    hold(1'b0, CPB / 4);
    hold(1'b1, 3 * CPB);
    check("glitch_busy_seen", {31'd0, busy_cyc > 0}, 1);
    check("glitch_busy_short", {31'd0, busy_cyc <= CPB}, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_fv", fv_cnt, 4);
    check("glitch_fe", fe_cnt, 1);
    check("glitch_count", digitCount, 0);

    // reset in the middle of the data bits of "9"
    send_byte(8'h34);
    check("mid_pre_count", digitCount, 1);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b0, 4);
    check("mid_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check_nums("midrst", 4'd0, 4'd0, 4'd0, 4'd0);
    check("midrst_count", digitCount, 0);
    check("midrst_busy", busy, 0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("midrst_fv", fv_cnt, 4);
    send_byte(8'h36);
    check("after_rst_count", digitCount, 1);
    send_byte(8'h0D);
    check("term5_fv", fv_cnt, 5);
    check_nums("c6", 4'd6, 4'd0, 4'd0, 4'd0);
    check("final_fe", fe_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
